// File: rtl/shift_pipe.sv
// Pipelined barrel shifter/rotator (SHL/SHR/ROL/ROR/ASR), one stage per shift-amount bit, SHW-cycle latency.
// Stalls whole pipe (bubbles kept) when output valid and not ready; optional out_carry under SHIFT_CARRY_EN.
module shift_pipe #(
   parameter int WIDTH = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_in_valid,
   output logic                     o_in_ready,
   input  logic [WIDTH-1:0]         i_in_data,
   input  logic [$clog2(WIDTH)-1:0] i_in_amt,
   input  logic [2:0]               i_in_op,
   output logic                     o_out_valid,
   input  logic                     i_out_ready,
   output logic [WIDTH-1:0]         o_out_data,
   output logic                     o_out_zero,
   output logic                     o_out_err
`ifdef SHIFT_CARRY_EN
   ,
   output logic                     o_out_carry
`endif
);

   localparam int SHW = $clog2(WIDTH);

   localparam logic [2:0] OP_SHL = 3'b000;
   localparam logic [2:0] OP_SHR = 3'b001;
   localparam logic [2:0] OP_ROL = 3'b010;
   localparam logic [2:0] OP_ROR = 3'b011;
   localparam logic [2:0] OP_ASR = 3'b100;

   typedef struct packed {
      logic             vld;
      logic             err;
      logic [2:0]       op;
      logic [SHW-1:0]   amt;
      logic [WIDTH-1:0] dat;
`ifdef SHIFT_CARRY_EN
      logic             cy;
`endif
   } stg_t;

   logic w_adv;
   stg_t w_in;
   logic r_zero;

   always_comb begin
      w_in     = '0;
      w_in.vld = i_in_valid;
      w_in.err = (i_in_op > OP_ASR);
      w_in.op  = i_in_op;
      w_in.amt = i_in_amt;
      w_in.dat = i_in_data;
   end

   for (genvar k = 0; k < SHW; k++) begin : g_stg
      localparam int S = 1 << k;
      stg_t w_src;
      stg_t w_nxt;
      stg_t r_q;
      logic w_unused;

      if (k == 0) begin : g_first
         assign w_src = w_in;
      end else begin : g_rest
         assign w_src = g_stg[k-1].r_q;
      end

      // Reserved ops never shift, so data passes through and carry stays 0.
      always_comb begin
         w_nxt = w_src;
         if (w_src.amt[k] && !w_src.err) begin
            case (w_src.op)
               OP_SHL:  w_nxt.dat = w_src.dat << S;
               OP_SHR:  w_nxt.dat = w_src.dat >> S;
               OP_ROL:  w_nxt.dat = (w_src.dat << S) | (w_src.dat >> (WIDTH - S));
               OP_ROR:  w_nxt.dat = (w_src.dat >> S) | (w_src.dat << (WIDTH - S));
               OP_ASR:  w_nxt.dat = $signed(w_src.dat) >>> S;
               default: w_nxt.dat = w_src.dat;
            endcase
`ifdef SHIFT_CARRY_EN
            w_nxt.cy = (w_src.op == OP_SHL || w_src.op == OP_ROL) ? w_src.dat[WIDTH-S]
                                                                  : w_src.dat[S-1];
`endif
         end
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            r_q <= '0;
         end else if (w_adv) begin
            r_q <= w_nxt;
         end
      end

      assign w_unused = ^{r_q.op, r_q.amt};
   end

   // Whole pipe advances together; a stalled output freezes every stage, bubbles included.
   assign w_adv      = !g_stg[SHW-1].r_q.vld || i_out_ready;
   assign o_in_ready = w_adv;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_zero <= 1'b0;
      end else if (w_adv) begin
         r_zero <= (g_stg[SHW-1].w_nxt.dat == '0);
      end
   end

   assign o_out_valid = g_stg[SHW-1].r_q.vld;
   assign o_out_data  = g_stg[SHW-1].r_q.dat;
   assign o_out_err   = g_stg[SHW-1].r_q.err;
   assign o_out_zero  = r_zero;
`ifdef SHIFT_CARRY_EN
   assign o_out_carry = g_stg[SHW-1].r_q.cy;
`endif

endmodule
